piso_unloader: RTL and testbench
================================

Name: piso_unloader

Overview:
- Parallel-in, serial-out unloader. It is the read-side counterpart of the team's loadable parallel register.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock.
- Supports stall via shift_en and back-to-back words with no idle gap.
- Sits between a parallel register bank and a serial link or checker.

Parameters:
- WIDTH, 4, word width in bits (>=2).
- LSB_FIRST, 0, 0 = MSB shifted out first; 1 = LSB first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- load_valid  input  1  D holds a word to unload
- load_ready  output  1  unloader can accept a word this cycle
- D  input  WIDTH  parallel data word
- shift_en  input  1  advance to next bit when 1; hold when 0
- sout  output  1  current serial bit (registered)
- sout_valid  output  1  sout carries a data bit
- busy  output  1  a word is in progress (state SHIFT)
- done  output  1  one-cycle pulse after the final bit of a word retires

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-word):
  - State IDLE; shift register 0; bit counter 0.
  - sout=0, sout_valid=0, busy=0, done=0; load_ready=1 once in IDLE.
  - A partial word is discarded; nothing resumes after reset.
- Handshake: a word is accepted on a rising edge where load_valid && load_ready. D is sampled only on that edge. load_valid without load_ready is ignored; D is not captured and nothing is queued.
- load_ready is combinational: (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && shift_en).
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on accept. On that edge: capture D, cnt=0, sout=first bit (D[WIDTH-1] if LSB_FIRST=0, else D[0]), sout_valid=1, busy=1.
  - Latency: the first bit is visible in the cycle immediately after the accept edge.
  - SHIFT with shift_en=0: sout, sout_valid, cnt and the shift register hold. No timeout.
  - SHIFT with shift_en=1 and cnt<WIDTH-1: cnt+1 and sout=next bit in configured order.
  - SHIFT with shift_en=1 and cnt==WIDTH-1 (last bit retires):
    - If a new word is accepted on the same edge: stay in SHIFT, cnt=0, sout=first bit of the new word, sout_valid stays 1. There is no gap cycle.
    - Otherwise: go to IDLE, sout=0, sout_valid=0, busy=0.
- done is registered and goes high for exactly one cycle following the edge on which the last bit retires. This holds in both the back-to-back and the go-idle cases.
- cnt width is clog2(WIDTH). cnt never exceeds WIDTH-1, and WIDTH bits are emitted per word exactly.
- shift_en is ignored in IDLE.
- The first bit of an accepted word is presented regardless of shift_en on the accept edge.

Test Plan:
- WIDTH=4, MSB-first: accept D=4'b1010 with shift_en=1 constantly -> sout=1,0,1,0 on 4 consecutive cycles with sout_valid=1. done pulses once in the 5th cycle; then sout_valid=0 and load_ready=1.
- Back-to-back: keep load_valid=1 with 4'b1010 then 4'b0110 presented at the last-bit cycle -> 8 contiguous valid bits 1,0,1,0,0,1,1,0. done pulses after bit 4 and after bit 8.
- Stall: D=4'b1100, drop shift_en for 2 cycles while bit index 1 is shown -> sout=1 held for 3 cycles total. Full sequence 1,1(x3),0,0; done arrives 2 cycles later than in the unstalled case.
- Busy ignore: while shifting 4'b1010, pulse load_valid with D=4'b1111 at bit index 1 -> load_ready=0 and output stays 1,0,1,0. No 1111 word appears afterward.
- Reset mid-word: assert reset low between clock edges during bit index 2 -> sout=0, sout_valid=0, busy=0 immediately (asynchronous). After release, load_ready=1 and the next word 4'b0011 shifts as 0,0,1,1.
- LSB_FIRST=1: accept D=4'b0111 -> sout=1,1,1,0. done pulses once afterward.

Source files
------------

// File: rtl/piso_unloader_if.sv
// Handshake and serial-output bundle for the parallel-in, serial-out unloader.
// The master side supplies the word and pacing; the slave side is the unloader.
interface piso_unloader_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] D;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, D, shift_en,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, D, shift_en,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_unloader.sv
// Parallel-in, serial-out unloader: accepts a word on valid/ready and emits it one
// bit per enabled clock, with back-to-back reload on the edge the last bit retires.
module piso_unloader #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            reset,
  piso_unloader_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             sout_q;
  logic             done_q;
  logic             retire;
  logic             accept;
  logic             load_ready;
  logic             first_bit;
  logic [WIDTH-1:0] first_rest;
  logic             next_bit;
  logic [WIDTH-1:0] next_rest;

  // Bit order: the register always holds the bits not yet shown, aligned for the next pick.
  always_comb begin
    if (LSB_FIRST != 0) begin
      first_bit  = bus.D[0];
      first_rest = {1'b0, bus.D[WIDTH-1:1]};
      next_bit   = shreg[0];
      next_rest  = {1'b0, shreg[WIDTH-1:1]};
    end else begin
      first_bit  = bus.D[WIDTH-1];
      first_rest = {bus.D[WIDTH-2:0], 1'b0};
      next_bit   = shreg[WIDTH-1];
      next_rest  = {shreg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (retire && !accept) begin
          state_next = IDLE;
        end else begin
          state_next = SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new word may be taken on the same edge the final bit of the current one retires.
  always_comb begin
    retire     = 1'b0;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        retire     = 1'b0;
        load_ready = 1'b1;
      end
      SHIFT: begin
        retire     = bus.shift_en && (cnt == LAST);
        load_ready = retire;
      end
      default: begin
        retire     = 1'b0;
        load_ready = 1'b0;
      end
    endcase
    accept = bus.load_valid && load_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      cnt    <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= retire;
      if (accept) begin
        shreg  <= first_rest;
        cnt    <= '0;
        sout_q <= first_bit;
      end else if (retire) begin
        shreg  <= '0;
        cnt    <= '0;
        sout_q <= 1'b0;
      end else if ((state == SHIFT) && bus.shift_en) begin
        shreg  <= next_rest;
        cnt    <= cnt + 1'b1;
        sout_q <= next_bit;
      end else begin
        shreg  <= shreg;
        cnt    <= cnt;
        sout_q <= sout_q;
      end
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_unloader.sv
// Directed bench for piso_unloader: MSB-first instance for the main scenarios and an
// LSB-first instance for bit order. Outputs are packed as {sout, sout_valid, busy, done}.
module tb_piso_unloader;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [3:0] pat;
  logic [7:0] pat8;
  logic [5:0] bits6;
  logic [5:0] en6;

  piso_unloader_if #(.WIDTH(4)) ifa ();
  piso_unloader_if #(.WIDTH(4)) ifb ();

  piso_unloader #(.WIDTH(4), .LSB_FIRST(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  piso_unloader #(.WIDTH(4), .LSB_FIRST(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic [3:0] sa;
  logic [3:0] sb;
  assign sa = {ifa.sout, ifa.sout_valid, ifa.busy, ifa.done};
  assign sb = {ifb.sout, ifb.sout_valid, ifb.busy, ifb.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    ifa.load_valid = 1'b0; ifa.D = 4'b0000; ifa.shift_en = 1'b0;
    ifb.load_valid = 1'b0; ifb.D = 4'b0000; ifb.shift_en = 1'b0;
    tick();
    tick();
    chk("reset_outputs", sa, 4'b0000);
    chk("reset_ready", {3'b000, ifa.load_ready}, 4'b0001);
    reset = 1'b1;
    tick();

    // Basic MSB-first word with shift_en held high
    pat = 4'b1010;
    ifa.D = pat; ifa.load_valid = 1'b1; ifa.shift_en = 1'b1;
    tick();
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("basic_bit", sa, {pat[3-i], 3'b110});
      if (i == 3) chk("basic_ready_last", {3'b000, ifa.load_ready}, 4'b0001);
      else        chk("basic_ready_mid", {3'b000, ifa.load_ready}, 4'b0000);
      tick();
    end
    chk("basic_done", sa, 4'b0001);
    chk("basic_idle_ready", {3'b000, ifa.load_ready}, 4'b0001);
    tick();
    chk("basic_after", sa, 4'b0000);

    // Back-to-back: second word presented during the last-bit cycle
    pat8 = 8'b1010_0110;
    ifa.D = 4'b1010; ifa.load_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        ifa.D = 4'b0110;
        #1;
        chk("b2b_ready", {3'b000, ifa.load_ready}, 4'b0001);
      end
      if (i == 4) ifa.load_valid = 1'b0;
      chk("b2b_bit", sa, {pat8[7-i], 2'b11, (i == 4)});
      tick();
    end
    chk("b2b_done", sa, 4'b0001);
    tick();
    chk("b2b_after", sa, 4'b0000);

    // Stall: shift_en low for two cycles while bit index 1 is shown
    bits6 = 6'b111100;
    en6   = 6'b100111;
    ifa.D = 4'b1100; ifa.load_valid = 1'b1;
    tick();
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ifa.shift_en = en6[5-i];
      chk("stall_bit", sa, {bits6[5-i], 3'b110});
      if (i == 5) begin
        ifa.shift_en = 1'b0;
        #1;
        chk("stall_last_hold_ready", {3'b000, ifa.load_ready}, 4'b0000);
        ifa.shift_en = 1'b1;
        #1;
        chk("stall_last_go_ready", {3'b000, ifa.load_ready}, 4'b0001);
      end
      tick();
    end
    chk("stall_done", sa, 4'b0001);
    tick();
    chk("stall_after", sa, 4'b0000);

    // Busy ignore: a request during bit index 1 is not captured
    pat = 4'b1010;
    ifa.D = pat; ifa.load_valid = 1'b1;
    tick();
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        ifa.D = 4'b1111; ifa.load_valid = 1'b1;
        #1;
        chk("ignore_ready", {3'b000, ifa.load_ready}, 4'b0000);
      end
      if (i == 2) begin
        ifa.load_valid = 1'b0; ifa.D = 4'b0000;
      end
      chk("ignore_bit", sa, {pat[3-i], 3'b110});
      tick();
    end
    chk("ignore_done", sa, 4'b0001);
    tick();
    chk("ignore_idle1", sa, 4'b0000);
    tick();
    chk("ignore_idle2", sa, 4'b0000);

    // Asynchronous reset during bit index 2, then a clean word
    ifa.D = 4'b1010; ifa.load_valid = 1'b1;
    tick();
    ifa.load_valid = 1'b0;
    tick();
    tick();
    chk("rstmid_before", sa, 4'b1110);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_async", sa, 4'b0000);
    chk("rstmid_ready", {3'b000, ifa.load_ready}, 4'b0001);
    #2 reset = 1'b1;
    tick();
    chk("rstmid_idle", sa, 4'b0000);
    pat = 4'b0011;
    ifa.D = pat; ifa.load_valid = 1'b1;
    tick();
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_bit", sa, {pat[3-i], 3'b110});
      tick();
    end
    chk("rstmid_done", sa, 4'b0001);

    // LSB-first instance: 0111 leaves as 1,1,1,0
    pat = 4'b1110;
    ifb.D = 4'b0111; ifb.load_valid = 1'b1; ifb.shift_en = 1'b1;
    tick();
    ifb.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lsb_bit", sb, {pat[3-i], 3'b110});
      tick();
    end
    chk("lsb_done", sb, 4'b0001);
    tick();
    chk("lsb_after", sb, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
